// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared memory geometry, data widths and arbiter FSM encodings
package dmem_arbiter_pkg;
    localparam int DEPTH  = 16384;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational grant between two requesters; rr_ptr breaks ties
module dmem_arb_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic rr_ptr,
    output logic any,
    output logic gnt
);
    // With both requesting the pointer decides, otherwise the lone requester wins
    always_comb begin
        any = valid0 | valid1;
        gnt = (valid0 & valid1) ? rr_ptr : valid1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port front end for the data memory, one request in flight at a time.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_error,
    output logic              dmem_fault
);
    state_t              state, state_n;
    logic                any, gnt, rr_ptr, accept;
    logic                port_q, we_q, err_q;
    logic [ADDR_W-1:0]   addr_q, sel_addr;
    logic [DATA_W-1:0]   wdata_q, rdata_q;

    dmem_arb_pick u_pick (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .rr_ptr (rr_ptr),
        .any    (any),
        .gnt    (gnt)
    );

`ifdef DMEM_ARB_RR_EN
    // After each grant the loser of that grant gets priority next time
    always_ff @(posedge clk or posedge rst)
        if (rst) rr_ptr <= 1'b0;
        else if (accept) rr_ptr <= ~gnt;
`else
    assign rr_ptr = 1'b0;
`endif

    // Accept only in IDLE; rst masks the combinational ready so nothing leaks out during reset
    always_comb begin
        accept     = (state == IDLE) & any & ~rst;
        req0_ready = accept & ~gnt;
        req1_ready = accept & gnt;
        sel_addr   = gnt ? req1_addr : req0_addr;
    end

    // Fixed four-cycle walk through the states; every request takes the same path
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ISSUE : IDLE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    // Latch the winning request and its range check at accept time
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            port_q  <= gnt;
            we_q    <= gnt ? req1_we : req0_we;
            err_q   <= sel_addr >= ADDR_W'(DEPTH);
            addr_q  <= sel_addr;
            wdata_q <= gnt ? req1_wdata : req0_wdata;
        end

    // Memory read data arrives one cycle after read_en; keep it only for good loads
    always_ff @(posedge clk or posedge rst)
        if (rst) rdata_q <= '0;
        else if (state == WAIT) rdata_q <= (~we_q & ~err_q) ? mem_read_data : '0;

    // Sticky fault flag, cleared only by reset
    always_ff @(posedge clk or posedge rst)
        if (rst) dmem_fault <= 1'b0;
        else if (mem_error) dmem_fault <= 1'b1;

    // Memory drive is live only in ISSUE, so the two enables can never overlap
    always_comb begin
        mem_write_en   = (state == ISSUE) & we_q & ~err_q;
        mem_read_en    = (state == ISSUE) & ~we_q & ~err_q;
        mem_address    = (state == ISSUE) ? addr_q : '0;
        mem_write_data = (state == ISSUE) ? wdata_q : '0;
        rsp0_valid     = (state == RESP) & ~port_q;
        rsp1_valid     = (state == RESP) & port_q;
        rsp0_rdata     = rsp0_valid ? rdata_q : '0;
        rsp1_rdata     = rsp1_valid ? rdata_q : '0;
        rsp0_err       = rsp0_valid & err_q;
        rsp1_err       = rsp1_valid & err_q;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural memory
module tb_dmem_arbiter;
    logic        clk, rst;
    logic        req0_valid, req0_ready, req0_we, rsp0_valid, rsp0_err;
    logic        req1_valid, req1_ready, req1_we, rsp1_valid, rsp1_err;
    logic [63:0] req0_addr, req0_wdata, rsp0_rdata, req1_addr, req1_wdata, rsp1_rdata;
    logic        mem_write_en, mem_read_en, mem_error, dmem_fault;
    logic [63:0] mem_address, mem_write_data, mem_read_data;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int en_both = 0;
    bit [63:0] mem_m [0:16383];

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_error(mem_error), .dmem_fault(dmem_fault)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Behavioural memory: registered read, valid the cycle after read_en
    always @(posedge clk) begin
        if (mem_write_en) mem_m[mem_address[13:0]] <= mem_write_data;
        if (mem_read_en) mem_read_data <= mem_m[mem_address[13:0]];
    end

    // Enable monitor sampled away from the active edge
    always @(negedge clk) begin
        if (mem_write_en) wr_cnt <= wr_cnt + 1;
        if (mem_read_en) rd_cnt <= rd_cnt + 1;
        if (mem_write_en && mem_read_en) en_both <= en_both + 1;
    end

    task automatic do_req(input bit p, input bit we, input logic [63:0] a, input logic [63:0] d,
                          output int lat, output logic [63:0] rd, output logic er, output bit other);
        bit acc = 0;
        lat = -1; rd = '0; er = 1'b0; other = 0;
        @(negedge clk);
        if (p) begin req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = d; end
        else   begin req0_valid = 1; req0_we = we; req0_addr = a; req0_wdata = d; end
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            acc = p ? req1_ready : req0_ready;
            if (!acc) @(negedge clk);
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        if (!acc) return;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            if (p ? rsp0_valid : rsp1_valid) other = 1;
            if (p ? rsp1_valid : rsp0_valid) begin
                lat = k; rd = p ? rsp1_rdata : rsp0_rdata; er = p ? rsp1_err : rsp0_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        req0_valid = 1; req0_addr = 64'd3;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", req0_ready); end
        checks++; if ({mem_write_en, mem_read_en} !== 2'b00) begin errors++; $display("FAIL rst_en got %b want 00", {mem_write_en, mem_read_en}); end
        checks++; if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, dmem_fault} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b want 0", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, dmem_fault}); end
        checks++; if (mem_address !== 64'd0) begin errors++; $display("FAIL rst_addr got %h want 0", mem_address); end
        req0_valid = 0;
        @(negedge clk);
        rst = 0;
        #1;
        checks++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0) begin errors++; $display("FAIL post_rst got %b want 0", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}); end
    endtask

    task automatic test_store_load;
        int lat; logic [63:0] rd; logic er; bit oth; int w0, r0;
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(0, 1, 64'd5, 64'hDEAD_BEEF, lat, rd, er, oth);
        checks++; if (lat !== 3) begin errors++; $display("FAIL st_lat got %0d want 3", lat); end
        checks++; if ({er, oth} !== 2'b00) begin errors++; $display("FAIL st_err got %b want 00", {er, oth}); end
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL st_rdata got %h want 0", rd); end
        checks++; if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 0) begin errors++; $display("FAIL st_pulses got w%0d r%0d want w1 r0", wr_cnt - w0, rd_cnt - r0); end
        do_req(0, 0, 64'd5, 64'd0, lat, rd, er, oth);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ld_lat got %0d want 3", lat); end
        checks++; if (rd !== 64'hDEAD_BEEF) begin errors++; $display("FAIL ld_rdata got %h want deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL ld_err got %b want 0", er); end
        checks++; if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 1) begin errors++; $display("FAIL ld_pulses got w%0d r%0d want w1 r1", wr_cnt - w0, rd_cnt - r0); end
    endtask

    task automatic test_bounds;
        int lat; logic [63:0] rd; logic er; bit oth; int w0, r0;
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(1, 0, 64'd16384, 64'd0, lat, rd, er, oth);
        checks++; if (lat !== 3 || er !== 1'b1) begin errors++; $display("FAIL oob_load got lat%0d err%b want lat3 err1", lat, er); end
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL oob_rdata got %h want 0", rd); end
        do_req(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h55, lat, rd, er, oth);
        checks++; if (lat !== 3 || er !== 1'b1) begin errors++; $display("FAIL oob_max got lat%0d err%b want lat3 err1", lat, er); end
        checks++; if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin errors++; $display("FAIL oob_pulses got w%0d r%0d want w0 r0", wr_cnt - w0, rd_cnt - r0); end
        do_req(1, 1, 64'd16383, 64'h1234_5678_9ABC_DEF0, lat, rd, er, oth);
        checks++; if (lat !== 3 || er !== 1'b0) begin errors++; $display("FAIL top_store got lat%0d err%b want lat3 err0", lat, er); end
        do_req(1, 0, 64'd16383, 64'd0, lat, rd, er, oth);
        checks++; if (er !== 1'b0 || rd !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL top_load got err%b %h want err0 123456789abcdef0", er, rd); end
        checks++; if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 1) begin errors++; $display("FAIL top_pulses got w%0d r%0d want w1 r1", wr_cnt - w0, rd_cnt - r0); end
    endtask

    task automatic test_arbitration;
        int order [8];
        int n = 0, c0 = 0, c1 = 0;
        bit both = 0;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        req0_we = 1; req0_addr = 64'd200; req0_wdata = 64'hA0;
        req1_we = 1; req1_addr = 64'd300; req1_wdata = 64'hB1;
        req0_valid = 1; req1_valid = 1;
        for (int cyc = 0; cyc < 100 && n < 8; cyc++) begin
            #1;
            if (req0_ready && req1_ready) both = 1;
            if (req0_ready) begin order[n] = 0; n++; c0++; end
            else if (req1_ready) begin order[n] = 1; n++; c1++; end
            @(negedge clk);
            if (c0 == 4) req0_valid = 0;
            if (c1 == 4) req1_valid = 0;
        end
        req0_valid = 0; req1_valid = 0;
        repeat (4) @(negedge clk);
        checks++; if (n !== 8) begin errors++; $display("FAIL arb_count got %0d want 8", n); end
        checks++; if (both) begin errors++; $display("FAIL arb_dual_ready got 1 want 0"); end
        for (int i = 0; i < n; i++) begin
`ifdef DMEM_ARB_RR_EN
            int exp = i % 2;
`else
            int exp = (i >= 4) ? 1 : 0;
`endif
            checks++; if (order[i] !== exp) begin errors++; $display("FAIL arb_order[%0d] got %0d want %0d", i, order[i], exp); end
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [63:0] rd; logic er; bit oth;
        bit seen = 0;
        @(negedge clk);
        req0_valid = 1; req0_we = 0; req0_addr = 64'd5;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rm_accept got %b want 1", req0_ready); end
        @(negedge clk); req0_valid = 0;
        @(negedge clk);
        rst = 1;
        #1;
        checks++; if ({mem_write_en, mem_read_en, rsp0_valid, rsp0_err, req0_ready} !== 5'b0 || rsp0_rdata !== 64'd0) begin errors++; $display("FAIL rm_outputs got %b %h want 0", {mem_write_en, mem_read_en, rsp0_valid, rsp0_err, req0_ready}, rsp0_rdata); end
        repeat (2) begin @(negedge clk); if (rsp0_valid || rsp1_valid) seen = 1; end
        rst = 0;
        repeat (3) begin @(negedge clk); if (rsp0_valid || rsp1_valid) seen = 1; end
        checks++; if (seen) begin errors++; $display("FAIL rm_ghost_rsp got 1 want 0"); end
        do_req(0, 0, 64'd5, 64'd0, lat, rd, er, oth);
        checks++; if (lat !== 3 || rd !== 64'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL rm_after got lat%0d %h err%b want lat3 deadbeef err0", lat, rd, er); end
    endtask

    task automatic test_fault;
        checks++; if (dmem_fault !== 1'b0) begin errors++; $display("FAIL fault_pre got %b want 0", dmem_fault); end
        @(negedge clk);
        req0_valid = 1; req0_we = 0; req0_addr = 64'd5;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL fault_accept got %b want 1", req0_ready); end
        @(negedge clk); req0_valid = 0; mem_error = 1;
        @(negedge clk); mem_error = 0;
        checks++; if (dmem_fault !== 1'b1) begin errors++; $display("FAIL fault_set got %b want 1", dmem_fault); end
        @(negedge clk);
        checks++; if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b0 || rsp0_rdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL fault_rsp got v%b e%b %h want v1 e0 deadbeef", rsp0_valid, rsp0_err, rsp0_rdata); end
        repeat (5) @(negedge clk);
        checks++; if (dmem_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b want 1", dmem_fault); end
        rst = 1;
        #1;
        checks++; if (dmem_fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %b want 0", dmem_fault); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_handoff;
        @(negedge clk);
        req0_valid = 1; req0_we = 1; req0_addr = 64'd7; req0_wdata = 64'h77;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL ho_accept0 got %b want 1", req0_ready); end
        @(negedge clk); req0_valid = 0;
        @(negedge clk);
        @(negedge clk);
        req1_valid = 1; req1_we = 0; req1_addr = 64'd5;
        #1;
        checks++; if (rsp0_valid !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL ho_resp got rsp0 %b rdy1 %b want 1 0", rsp0_valid, req1_ready); end
        @(negedge clk);
        #1;
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL ho_grant1 got rdy1 %b rdy0 %b want 1 0", req1_ready, req0_ready); end
        @(negedge clk);
        #1;
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL ho_pulse_width got %b want 0", req1_ready); end
        req1_valid = 0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL ho_rsp1 got v%b %h want v1 deadbeef", rsp1_valid, rsp1_rdata); end
    endtask

    initial begin
        rst = 1; mem_error = 0;
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        repeat (2) @(negedge clk);
        test_reset;
        test_store_load;
        test_bounds;
        test_arbitration;
        test_reset_mid;
        test_fault;
        test_handoff;
        repeat (2) @(negedge clk);
        checks++; if (en_both !== 0) begin errors++; $display("FAIL en_exclusive got %0d want 0", en_both); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
